syn_calc_par: RTL

Parallel, streaming BCH syndrome calculator: next generation of the single-shot syndrome block in the hard-decision decoder front end. It consumes the received word P bits per beat over a valid/ready stream, so it needs no full-width codeword bus. It evaluates the odd syndromes by Horner's rule and derives the even syndromes by GF squaring, all with a runtime-selectable field size m. It presents S1..S2t with an all-zero flag to the downstream key-equation solver through a held output handshake.

---
 rtl/syn_calc_par_if.sv | 24 ++
 rtl/syn_calc_par.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/syn_calc_par_if.sv
// Stream-in / result-out handshake bundle for the parallel BCH syndrome calculator.
interface syn_calc_par_if #(
    parameter int unsigned P     = 8,
    parameter int unsigned T_MAX = 4,
    parameter int unsigned M_MAX = 10
) ();
    logic                         in_valid;
    logic                         in_ready;
    logic [P-1:0]                 in_bits;
    logic                         out_valid;
    logic                         out_ready;
    logic [2*T_MAX*M_MAX-1:0]     syndromes;
    logic                         zero_flag;

    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, syndromes, zero_flag
    );

    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, syndromes, zero_flag
    );
endinterface

// File: rtl/syn_calc_par.sv
// Streaming BCH syndrome calculator: Horner evaluation of odd S_j over P-bit beats,
// even S_j by GF squaring, result held until accepted.
module syn_calc_par #(
    parameter int unsigned N_MAX = 1023,
    parameter int unsigned T_MAX = 4,
    parameter int unsigned M_MAX = 10,
    parameter int unsigned P     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [9:0]          n,
    input  logic [3:0]          t,
    input  logic [3:0]          m,
    syn_calc_par_if.slave       bus,
    output logic                cfg_err,
    output logic                busy
);
    localparam int unsigned NS = 2 * T_MAX;
    localparam int unsigned MW = M_MAX + 1;
    localparam int unsigned CW = $clog2(N_MAX + 1) + 1;
    localparam logic [3:0]  M_MAX_L = 4'(M_MAX);
    localparam logic [3:0]  T_MAX_L = 4'(T_MAX);
    localparam logic [16:0] N_MAX_L = 17'(N_MAX);

    typedef enum logic [1:0] {StIdle, StLoad, StSquare, StHold} state_e;

    state_e              state_q, state_d;
    logic [9:0]          n_q, n_d;
    logic [3:0]          t_q, t_d, m_q, m_d, k_q, k_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [M_MAX-1:0]    syn_q [NS];
    logic [M_MAX-1:0]    syn_d [NS];
    logic                zero_q, zero_d, err_q, err_d;
    logic                cfg_ok, beat, last_beat, any_set;
    logic [16:0]         n_lim;
    logic [CW-1:0]       remain, nvalid;
    logic [M_MAX-1:0]    acc;

    function automatic logic [M_MAX:0] prim_poly(input logic [3:0] mm);
        logic [10:0] p;
        case (mm)
            4'd3:    p = 11'h00B;
            4'd4:    p = 11'h013;
            4'd5:    p = 11'h025;
            4'd6:    p = 11'h043;
            4'd7:    p = 11'h089;
            4'd8:    p = 11'h11D;
            4'd9:    p = 11'h211;
            4'd10:   p = 11'h409;
            default: p = 11'h000;
        endcase
        return MW'(p);
    endfunction

    function automatic logic [M_MAX-1:0] mul_alpha(input logic [M_MAX-1:0] a,
                                                   input logic [3:0] mm);
        logic [M_MAX:0] s;
        s = {a, 1'b0};
        for (int i = 3; i <= M_MAX; i++) begin
            if (mm == 4'(i) && s[i]) s = s ^ prim_poly(mm);
        end
        return s[M_MAX-1:0];
    endfunction

    // Horner over the coefficients of a, multiplying by a itself.
    function automatic logic [M_MAX-1:0] gf_sq(input logic [M_MAX-1:0] a, input logic [3:0] mm);
        logic [M_MAX-1:0] r;
        r = '0;
        for (int i = M_MAX - 1; i >= 0; i--) begin
            r = mul_alpha(r, mm);
            if (a[i]) r = r ^ a;
        end
        return r;
    endfunction

    always_comb begin
        n_lim  = (17'd1 << m) - 17'd1;
        cfg_ok = (m >= 4'd3) && (m <= M_MAX_L) && (t >= 4'd1) && (t <= T_MAX_L) &&
                 (n != 10'd0) && ({7'd0, n} <= n_lim) && ({7'd0, n} <= N_MAX_L);
        remain    = CW'(n_q) - cnt_q;
        last_beat = remain <= CW'(P);
        nvalid    = last_beat ? remain : CW'(P);
        beat      = (state_q == StLoad) && bus.in_valid;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = cfg_ok ? StLoad : StHold;
            StLoad:   if (beat && last_beat) state_d = StSquare;
            StSquare: if (k_q == t_q) state_d = StHold;
            StHold:   if (bus.out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == StLoad);
        bus.out_valid = (state_q == StHold);
        busy          = (state_q != StIdle);
        bus.zero_flag = zero_q;
        cfg_err       = err_q;
        bus.syndromes = '0;
        for (int s = 0; s < NS; s++) bus.syndromes[s*M_MAX +: M_MAX] = syn_q[s];
    end

    // Datapath next values
    always_comb begin
        n_d     = n_q;
        t_d     = t_q;
        m_d     = m_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        err_d   = err_q;
        syn_d   = syn_q;
        acc     = '0;
        any_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    n_d    = n;
                    t_d    = t;
                    m_d    = m;
                    k_d    = 4'd1;
                    cnt_d  = '0;
                    zero_d = 1'b0;
                    err_d  = !cfg_ok;
                    for (int s = 0; s < NS; s++) syn_d[s] = '0;
                end
            end
            StLoad: begin
                if (beat) begin
                    // Bits are consumed MSB first; only odd slots below 2t are live.
                    for (int i = 0; i < P; i++) begin
                        if (CW'(i) < nvalid) begin
                            for (int j = 1; j < NS; j += 2) begin
                                if (5'(j) < {t_q, 1'b0}) begin
                                    acc = syn_d[j-1];
                                    for (int r = 0; r < j; r++) acc = mul_alpha(acc, m_q);
                                    syn_d[j-1] = acc ^ M_MAX'(bus.in_bits[P-1-i]);
                                end
                            end
                        end
                    end
                    cnt_d = cnt_q + nvalid;
                end
            end
            StSquare: begin
                for (int kk = 1; kk <= T_MAX; kk++) begin
                    if (k_q == 4'(kk)) syn_d[2*kk-1] = gf_sq(syn_q[kk-1], m_q);
                end
                k_d = k_q + 4'd1;
                for (int s = 0; s < NS; s++) any_set = any_set | (|syn_d[s]);
                if (k_q == t_q) zero_d = !any_set;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q    <= '0;
            t_q    <= '0;
            m_q    <= '0;
            k_q    <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
            for (int s = 0; s < NS; s++) syn_q[s] <= '0;
        end else begin
            n_q    <= n_d;
            t_q    <= t_d;
            m_q    <= m_d;
            k_q    <= k_d;
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
            err_q  <= err_d;
            for (int s = 0; s < NS; s++) syn_q[s] <= syn_d[s];
        end
    end
endmodule
